c_matrix_event_capture: RTL and testbench



---
 rtl/c_matrix_pkg.sv | 34 +++
 rtl/c_matrix_event_capture_if.sv | 27 ++
 rtl/c_matrix_rec_fifo.sv | 59 +++++
 rtl/c_matrix_event_capture.sv | 117 +++++++++++
 tb/tb_c_matrix_event_capture.sv | 227 ++++++++++++++++++++++
 5 files changed

// File: rtl/c_matrix_pkg.sv
// Shared definitions for the C-element matrix event capture block.
// Flag bit positions follow the matrix output ordering.
package c_matrix_pkg;

    localparam int FLAG_W   = 9;
    localparam int TS_W_DEF = 8;

    localparam int COL_ANY0 = 0;
    localparam int COL_ANY1 = 1;
    localparam int COL_ANY2 = 2;
    localparam int ANY      = 3;
    localparam int ROW_MAJ0 = 4;
    localparam int ROW_MAJ1 = 5;
    localparam int ROW_MAJ2 = 6;
    localparam int COL_MAJ  = 7;
    localparam int MAJ_ANY  = 8;

    typedef enum logic {
        STABLE   = 1'b0,
        SETTLING = 1'b1
    } filt_state_e;

    typedef struct packed {
        logic [FLAG_W-1:0]   flags;
        logic [TS_W_DEF-1:0] ts;
    } rec_t;

    // Each "any" summary bit must equal the OR of the bits it summarises.
    function automatic logic flags_consistent(input logic [FLAG_W-1:0] f);
        return (f[ANY] == |f[COL_ANY2:COL_ANY0]) &&
               (f[MAJ_ANY] == |f[COL_MAJ:ROW_MAJ0]);
    endfunction

endpackage

// File: rtl/c_matrix_event_capture_if.sv
// Record readout handshake: the capture block drives the head record,
// the chip-level readout logic returns ready.
interface c_matrix_event_capture_if #(
    parameter int TS_W = 8
);
    import c_matrix_pkg::*;

    logic              rec_valid_o;
    logic              rec_ready_i;
    logic [FLAG_W-1:0] rec_flags_o;
    logic [TS_W-1:0]   rec_ts_o;

    modport master (
        output rec_valid_o,
        output rec_flags_o,
        output rec_ts_o,
        input  rec_ready_i
    );

    modport slave (
        input  rec_valid_o,
        input  rec_flags_o,
        input  rec_ts_o,
        output rec_ready_i
    );

endinterface

// File: rtl/c_matrix_rec_fifo.sv
// Fall-through record FIFO with valid/ready pop and a drop strobe for
// pushes refused while full.
module c_matrix_rec_fifo #(
    parameter int WIDTH = 17,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             pop_i,
    output logic             valid_o,
    output logic [WIDTH-1:0] data_o,
    output logic             drop_o
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             empty, full, do_pop, do_push;

    // DEPTH is a power of two, so the count MSB alone marks full.
    assign empty   = (count_q == '0);
    assign full    = count_q[AW];
    assign do_pop  = pop_i & ~empty;
    assign do_push = push_i & (~full | do_pop);
    assign drop_o  = push_i & full & ~do_pop;

    assign valid_o = ~empty;
    assign data_o  = empty ? '0 : mem_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q + AW'(do_push);
        rd_ptr_d = rd_ptr_q + AW'(do_pop);
        count_d  = count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

endmodule

// File: rtl/c_matrix_event_capture.sv
// Synchronises and debounces the matrix flag vector, timestamps each settled
// change into the record FIFO and keeps sticky overflow/inconsistency flags.
module c_matrix_event_capture
    import c_matrix_pkg::*;
#(
    parameter int STABLE_CYCLES = 4,
    parameter int DEPTH         = 4,
    parameter int TS_W          = 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [FLAG_W-1:0]         flags_i,
    output logic [FLAG_W-1:0]         level_o,
    c_matrix_event_capture_if.master  rec,
    output logic                      ovf_o,
    output logic                      err_o,
    input  logic                      clr_i
);

    localparam int                CNT_W    = $clog2(STABLE_CYCLES + 1);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

    logic [FLAG_W-1:0] s1_q, s2_q;
    logic [FLAG_W-1:0] cand_q, cand_d;
    logic [FLAG_W-1:0] level_q, level_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [TS_W-1:0]   ts_q, ts_d;
    filt_state_e       state_q, state_d;
    logic              ovf_q, ovf_d;
    logic              err_q, err_d;

    logic                     commit, push, drop, fifo_valid;
    logic [FLAG_W+TS_W-1:0]   fifo_data;

    always_comb begin
        state_d = state_q;
        cand_d  = cand_q;
        cnt_d   = cnt_q;
        level_d = level_q;
        commit  = 1'b0;
        case (state_q)
            STABLE: begin
                if (s2_q != cand_q) begin
                    cand_d  = s2_q;
                    cnt_d   = '0;
                    state_d = SETTLING;
                end
            end
            SETTLING: begin
                if (s2_q != cand_q) begin
                    cand_d = s2_q;
                    cnt_d  = '0;
                end else if (cnt_q == CNT_LAST) begin
                    commit  = 1'b1;
                    level_d = cand_q;
                    state_d = STABLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = STABLE;
        endcase
    end

    // A commit that lands back on the old level is a glitch: no record.
    assign push  = commit & (cand_q != level_q);
    assign ts_d  = ts_q + TS_W'(1);
    // A same-cycle set beats clr_i.
    assign ovf_d = drop | (ovf_q & ~clr_i);
    assign err_d = (commit & ~flags_consistent(cand_q)) | (err_q & ~clr_i);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_q    <= '0;
            s2_q    <= '0;
            cand_q  <= '0;
            level_q <= '0;
            cnt_q   <= '0;
            ts_q    <= '0;
            state_q <= STABLE;
            ovf_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            s1_q    <= flags_i;
            s2_q    <= s1_q;
            cand_q  <= cand_d;
            level_q <= level_d;
            cnt_q   <= cnt_d;
            ts_q    <= ts_d;
            state_q <= state_d;
            ovf_q   <= ovf_d;
            err_q   <= err_d;
        end
    end

    c_matrix_rec_fifo #(
        .WIDTH (FLAG_W + TS_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .push_i      (push),
        .push_data_i ({cand_q, ts_q}),
        .pop_i       (rec.rec_ready_i),
        .valid_o     (fifo_valid),
        .data_o      (fifo_data),
        .drop_o      (drop)
    );

    assign level_o         = level_q;
    assign ovf_o           = ovf_q;
    assign err_o           = err_q;
    assign rec.rec_valid_o = fifo_valid;
    assign rec.rec_flags_o = fifo_data[FLAG_W+TS_W-1:TS_W];
    assign rec.rec_ts_o    = fifo_data[TS_W-1:0];

endmodule

// File: tb/tb_c_matrix_event_capture.sv
// Directed bench: stimulus queues expected records, a monitor pops and
// compares them on every accepted handshake.
module tb_c_matrix_event_capture;
    import c_matrix_pkg::*;

    localparam int STABLE_CYCLES = 4;
    localparam int DEPTH         = 4;
    localparam int TS_W          = 8;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [FLAG_W-1:0] flags_i;
    logic [FLAG_W-1:0] level_o;
    logic              ovf_o, err_o, clr_i;

    c_matrix_event_capture_if #(.TS_W(TS_W)) rec_if ();

    c_matrix_event_capture #(
        .STABLE_CYCLES (STABLE_CYCLES),
        .DEPTH         (DEPTH),
        .TS_W          (TS_W)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .flags_i (flags_i),
        .level_o (level_o),
        .rec     (rec_if),
        .ovf_o   (ovf_o),
        .err_o   (err_o),
        .clr_i   (clr_i)
    );

    always #5 clk = ~clk;

    int              total = 0;
    int              bad   = 0;
    rec_t            exp_q [$];
    logic [TS_W-1:0] model_ts = '0;
    logic [FLAG_W-1:0] exp_level = '0;

    // Reference timestamp: counts edges since reset, wraps at 2^TS_W.
    always @(posedge clk) begin
        if (!rst_n) model_ts <= '0;
        else        model_ts <= model_ts + 8'd1;
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end else begin
            $display("ok   %s = %0h", name, got);
        end
    endtask

    // Monitor: every accepted record must match the scoreboard head.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && rec_if.rec_valid_o === 1'b1 && rec_if.rec_ready_i === 1'b1) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL rec_unexpected got flags=%0h ts=%0h exp none",
                         rec_if.rec_flags_o, rec_if.rec_ts_o);
            end else begin
                rec_t e;
                e = exp_q.pop_front();
                if (rec_if.rec_flags_o !== e.flags || rec_if.rec_ts_o !== e.ts) begin
                    bad++;
                    $display("FAIL rec got flags=%0h ts=%0h exp flags=%0h ts=%0h",
                             rec_if.rec_flags_o, rec_if.rec_ts_o, e.flags, e.ts);
                end else begin
                    $display("ok   rec flags=%0h ts=%0h", e.flags, e.ts);
                end
            end
        end
    end

    // Drive v so it is first sampled at the next edge E0; commit lands at E6.
    task automatic settle(input logic [FLAG_W-1:0] v, input bit exp_rec,
                          input bit clr_c, input bit pop_c);
        rec_t r;
        @(posedge clk);
        #1;
        flags_i = v;
        if (exp_rec) begin
            r.flags = v;
            r.ts    = model_ts + 8'(STABLE_CYCLES + 2);
            exp_q.push_back(r);
        end
        repeat (STABLE_CYCLES + 2) @(posedge clk);
        #1;
        clr_i = clr_c;
        if (pop_c) rec_if.rec_ready_i = 1'b1;
        @(negedge clk);
        chk("level_before_commit", 32'(level_o), 32'(exp_level));
        @(posedge clk);
        #1;
        clr_i = 1'b0;
        if (pop_c) rec_if.rec_ready_i = 1'b0;
        exp_level = v;
        @(negedge clk);
        chk("level_after_commit", 32'(level_o), 32'(v));
    endtask

    task automatic drain();
        rec_if.rec_ready_i = 1'b1;
        repeat (DEPTH + 4) @(posedge clk);
        @(negedge clk);
        chk("drain_valid", 32'(rec_if.rec_valid_o), 32'd0);
        chk("drain_queue_left", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic clr_pulse();
        @(posedge clk);
        #1;
        clr_i = 1'b1;
        @(posedge clk);
        #1;
        clr_i = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        rst_n              = 1'b0;
        flags_i            = 9'h1FF;
        clr_i              = 1'b0;
        rec_if.rec_ready_i = 1'b1;

        // 1. reset
        repeat (3) @(posedge clk);
        #1;
        rst_n   = 1'b1;
        flags_i = 9'h000;
        @(negedge clk);
        chk("rst_level", 32'(level_o), 32'd0);
        chk("rst_valid", 32'(rec_if.rec_valid_o), 32'd0);
        chk("rst_flags", 32'(rec_if.rec_flags_o), 32'd0);
        chk("rst_ts", 32'(rec_if.rec_ts_o), 32'd0);
        chk("rst_ovf", 32'(ovf_o), 32'd0);
        chk("rst_err", 32'(err_o), 32'd0);
        repeat (10) @(posedge clk);
        @(negedge clk);
        chk("rst_valid_idle", 32'(rec_if.rec_valid_o), 32'd0);

        // 2. single step
        settle(9'h009, 1'b1, 1'b0, 1'b0);
        chk("step_err", 32'(err_o), 32'd0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("step_queue_left", 32'(exp_q.size()), 32'd0);

        // 3. glitch back to the committed value
        @(posedge clk);
        #1;
        flags_i = 9'h012;
        repeat (3) @(posedge clk);
        #1;
        flags_i = 9'h009;
        repeat (15) @(posedge clk);
        @(negedge clk);
        chk("glitch_level", 32'(level_o), 32'h009);
        chk("glitch_valid", 32'(rec_if.rec_valid_o), 32'd0);
        chk("glitch_err", 32'(err_o), 32'd0);

        // 4. overflow with the consumer stalled
        rec_if.rec_ready_i = 1'b0;
        settle(9'h012, 1'b1, 1'b0, 1'b0);
        chk("ovf_err_012", 32'(err_o), 32'd1);
        settle(9'h024, 1'b1, 1'b0, 1'b0);
        settle(9'h009, 1'b1, 1'b0, 1'b0);
        settle(9'h012, 1'b1, 1'b0, 1'b0);
        chk("ovf_before", 32'(ovf_o), 32'd0);
        settle(9'h009, 1'b0, 1'b0, 1'b0);
        chk("ovf_after", 32'(ovf_o), 32'd1);
        chk("ovf_stall_valid", 32'(rec_if.rec_valid_o), 32'd1);
        chk("ovf_stall_head", 32'(rec_if.rec_flags_o), 32'h012);
        drain();
        clr_pulse();
        chk("ovf_cleared", 32'(ovf_o), 32'd0);
        chk("err_cleared", 32'(err_o), 32'd0);

        // 5. inconsistent commits and clr collision
        settle(9'h001, 1'b1, 1'b0, 1'b0);
        chk("incons_err", 32'(err_o), 32'd1);
        clr_pulse();
        chk("incons_err_clr", 32'(err_o), 32'd0);
        settle(9'h010, 1'b1, 1'b1, 1'b0);
        chk("incons_err_set_wins", 32'(err_o), 32'd1);
        repeat (4) @(posedge clk);
        @(negedge clk);
        chk("incons_queue_left", 32'(exp_q.size()), 32'd0);
        clr_pulse();

        // 6. full FIFO with pop and push on the same edge
        rec_if.rec_ready_i = 1'b0;
        settle(9'h009, 1'b1, 1'b0, 1'b0);
        settle(9'h012, 1'b1, 1'b0, 1'b0);
        settle(9'h024, 1'b1, 1'b0, 1'b0);
        settle(9'h009, 1'b1, 1'b0, 1'b0);
        settle(9'h012, 1'b1, 1'b0, 1'b1);
        chk("full_popush_ovf", 32'(ovf_o), 32'd0);
        drain();

        // idle past a full timestamp period, then commit across the wrap
        repeat (260) @(posedge clk);
        begin
            int n = 0;
            #1;
            while (model_ts != 8'd252 && n < 300) begin
                @(posedge clk);
                #1;
                n++;
            end
            chk("wrap_align", 32'(model_ts), 32'd252);
        end
        settle(9'h024, 1'b1, 1'b0, 1'b0);
        repeat (4) @(posedge clk);
        @(negedge clk);
        chk("wrap_queue_left", 32'(exp_q.size()), 32'd0);
        chk("wrap_ovf", 32'(ovf_o), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
